// File: rtl/opt_rand_gen.sv
// opt_rand_gen: move-proposal generator for one annealing replica.
// Keeps a private xorshift64 state and draws city indices by rejection
// sampling. Each request yields one or-opt, 2-opt or through descriptor,
// along with two 32-bit random words for the metropolis and exchange steps.
// Optional macro OPT_RAND_RETRY_LIMIT_EN bounds the number of rejected
// draws per move and reports an abort on o_err.
module opt_rand_gen #(
    parameter int CITY_NUM  = 32,
    parameter int BASE_W    = 5,
    parameter int MAX_SEG   = 3,
    parameter int RETRY_MAX = 63,
    parameter int CW        = $clog2(CITY_NUM)
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           seed_we,
    input  logic [63:0]                    seed_i,
    output logic [63:0]                    seed_o,
    input  logic [BASE_W-1:0]              base_id,
    input  logic                           start,
    input  logic [1:0]                     mode,
    output logic                           busy,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [1:0]                     o_com,
    output logic [BASE_W-1:0]              o_base_id,
    output logic [CW-1:0]                  o_k,
    output logic [CW-1:0]                  o_l,
    output logic [$clog2(MAX_SEG+1)-1:0]   o_seg,
    output logic [31:0]                    o_r_met,
    output logic [31:0]                    o_r_exc,
    output logic                           o_err
);

    localparam int SW = $clog2(MAX_SEG+1);

    localparam logic [1:0] COM_THR = 2'd0;
    localparam logic [1:0] COM_OR  = 2'd1;
    localparam logic [1:0] COM_TWO = 2'd2;

    typedef enum logic [2:0] {
        S_IDLE, S_K, S_SEG, S_L, S_MET, S_EXC, S_OUT
    } state_t;

    state_t         state;
    logic [63:0]    seed;
    logic [1:0]     com_reg;
    logic [CW-1:0]  k_reg;
    logic [SW-1:0]  seg_reg;

    logic [63:0]    x1, x2, nxt;
    logic [31:0]    cand_idx, cand_seg, k_ext, seg_ext;
    logic [1:0]     mode_com;
    logic           accept, draw_state, do_draw;
    logic           k_ok, seg_ok, l_in_range, l_in_window, l_far;
    logic           l_accept, l_back;
    logic           abort;

    assign seed_o = seed;

    // Next xorshift64 value and the candidates carved out of it
    assign x1 = seed ^ (seed << 13);
    assign x2 = x1 ^ (x1 >> 7);
    assign nxt = x2 ^ (x2 << 17);

    assign cand_idx = 32'(nxt[CW-1:0]);
    assign cand_seg = 32'(nxt[SW-1:0]);
    assign k_ext    = 32'(k_reg);
    assign seg_ext  = 32'(seg_reg);

    // Mode 3 is folded into THR so the datapath only ever sees three commands
    assign mode_com = (mode == 2'd1) ? COM_OR :
                      (mode == 2'd2) ? COM_TWO : COM_THR;

    assign accept = (state == S_IDLE) && start && !out_valid;

    // A seed load overrides the draw of that cycle; the state simply waits
    assign draw_state = ((state == S_K) && (com_reg != COM_THR)) ||
                        (state == S_SEG) || (state == S_L) ||
                        (state == S_MET) || (state == S_EXC);
    assign do_draw = draw_state && !seed_we;

    // Acceptance windows for each draw state
    assign k_ok = (com_reg == COM_OR) ?
                  (cand_idx >= 32'd1 && cand_idx <= 32'(CITY_NUM - 1)) :
                  (cand_idx >= 32'd1 && cand_idx <= 32'(CITY_NUM - 2));
    assign seg_ok = (cand_seg >= 32'd1) && (cand_seg <= 32'(MAX_SEG)) &&
                    (k_ext + cand_seg - 32'd1 <= 32'(CITY_NUM - 1));
    assign l_in_range  = cand_idx <= 32'(CITY_NUM - 1);
    assign l_in_window = (cand_idx >= k_ext - 32'd1) &&
                         (cand_idx <= k_ext + seg_ext - 32'd1);
    assign l_far       = (cand_idx >= k_ext + 32'd2) || (k_ext >= cand_idx + 32'd2);

    assign l_accept = (com_reg == COM_OR) ? (l_in_range && !l_in_window)
                                          : (l_in_range && l_far);
    assign l_back   = (com_reg == COM_OR) ? (l_in_range && l_in_window)
                                          : !(l_in_range && l_far);

`ifdef OPT_RAND_RETRY_LIMIT_EN
    logic [5:0] attempts;
    logic       err_q;
    logic       reject;

    assign reject = do_draw && (((state == S_K) && !k_ok) ||
                                ((state == S_SEG) && !seg_ok) ||
                                ((state == S_L) && !l_accept));
    assign abort  = reject && ((32'(attempts) + 32'd1) == 32'(RETRY_MAX));
    assign o_err  = err_q;

    // Attempt counter per move and sticky abort flag cleared by the transfer
    always_ff @(posedge clk) begin
        if (reset) begin
            attempts <= '0;
            err_q    <= 1'b0;
        end else begin
            if (accept)
                attempts <= '0;
            else if (reject)
                attempts <= attempts + 6'd1;
            if (abort)
                err_q <= 1'b1;
            else if (out_valid && out_ready)
                err_q <= 1'b0;
        end
    end
`else
    assign abort = 1'b0;
    assign o_err = 1'b0;
`endif

    // Move sequencer: seed register, draw states and registered descriptor
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= S_IDLE;
            seed      <= 64'h1;
            com_reg   <= COM_THR;
            k_reg     <= '0;
            seg_reg   <= '0;
            busy      <= 1'b0;
            out_valid <= 1'b0;
            o_com     <= COM_THR;
            o_base_id <= '0;
            o_k       <= '0;
            o_l       <= '0;
            o_seg     <= '0;
            o_r_met   <= '0;
            o_r_exc   <= '0;
        end else begin
            if (seed_we)
                seed <= seed_i;
            else if (do_draw)
                seed <= nxt;

            if (abort) begin
                o_com     <= COM_THR;
                o_k       <= '0;
                o_l       <= '0;
                o_seg     <= '0;
                out_valid <= 1'b1;
                busy      <= 1'b0;
                state     <= S_OUT;
            end else begin
                case (state)
                    S_IDLE: begin
                        if (accept) begin
                            o_base_id <= base_id;
                            com_reg   <= mode_com;
                            busy      <= 1'b1;
                            state     <= S_K;
                        end
                    end
                    S_K: begin
                        if (com_reg == COM_THR) begin
                            o_com     <= COM_THR;
                            o_k       <= '0;
                            o_l       <= '0;
                            o_seg     <= '0;
                            out_valid <= 1'b1;
                            busy      <= 1'b0;
                            state     <= S_OUT;
                        end else if (do_draw && k_ok) begin
                            k_reg   <= nxt[CW-1:0];
                            seg_reg <= '0;
                            state   <= (com_reg == COM_OR) ? S_SEG : S_L;
                        end
                    end
                    S_SEG: begin
                        if (do_draw && seg_ok) begin
                            seg_reg <= nxt[SW-1:0];
                            state   <= S_L;
                        end
                    end
                    S_L: begin
                        if (do_draw && l_accept) begin
                            if (com_reg == COM_OR) begin
                                o_k   <= k_reg;
                                o_l   <= nxt[CW-1:0];
                                o_seg <= seg_reg;
                            end else begin
                                o_k   <= (cand_idx < k_ext) ? nxt[CW-1:0] : k_reg;
                                o_l   <= (cand_idx < k_ext) ? k_reg : nxt[CW-1:0];
                                o_seg <= '0;
                            end
                            state <= S_MET;
                        end else if (do_draw && l_back) begin
                            state <= S_K;
                        end
                    end
                    S_MET: begin
                        if (do_draw) begin
                            o_r_met <= nxt[31:0];
                            state   <= S_EXC;
                        end
                    end
                    S_EXC: begin
                        if (do_draw) begin
                            o_r_exc   <= nxt[31:0];
                            o_com     <= com_reg;
                            out_valid <= 1'b1;
                            busy      <= 1'b0;
                            state     <= S_OUT;
                        end
                    end
                    S_OUT: begin
                        if (out_ready) begin
                            out_valid <= 1'b0;
                            state     <= S_IDLE;
                        end
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_opt_rand_gen.sv
// Directed bench for opt_rand_gen: reset state, seed load, TWO/THR/OR moves,
// handshake stalls, reset mid-move and (with OPT_RAND_RETRY_LIMIT_EN) abort.
module tb_opt_rand_gen;

    localparam int CITY_NUM = 32;
    localparam int BASE_W   = 5;
    localparam int MAX_SEG  = 3;
    localparam int CW       = 5;
    localparam int SW       = 2;
`ifdef OPT_RAND_RETRY_LIMIT_EN
    localparam int RETRY_MAX = 2;
`else
    localparam int RETRY_MAX = 63;
`endif

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              seed_we = 1'b0;
    logic [63:0]       seed_i = '0;
    logic [63:0]       seed_o;
    logic [BASE_W-1:0] base_id = '0;
    logic              start = 1'b0;
    logic [1:0]        mode = '0;
    logic              busy, out_valid;
    logic              out_ready = 1'b0;
    logic [1:0]        o_com;
    logic [BASE_W-1:0] o_base_id;
    logic [CW-1:0]     o_k, o_l;
    logic [SW-1:0]     o_seg;
    logic [31:0]       o_r_met, o_r_exc;
    logic              o_err;

    int          checks = 0;
    int          errors = 0;
    logic [63:0] exp_seed = 64'h1;
    logic [31:0] exp_met = '0;
    logic [31:0] exp_exc = '0;

    opt_rand_gen #(
        .CITY_NUM(CITY_NUM), .BASE_W(BASE_W), .MAX_SEG(MAX_SEG), .RETRY_MAX(RETRY_MAX)
    ) dut (
        .clk(clk), .reset(reset), .seed_we(seed_we), .seed_i(seed_i), .seed_o(seed_o),
        .base_id(base_id), .start(start), .mode(mode), .busy(busy),
        .out_valid(out_valid), .out_ready(out_ready), .o_com(o_com),
        .o_base_id(o_base_id), .o_k(o_k), .o_l(o_l), .o_seg(o_seg),
        .o_r_met(o_r_met), .o_r_exc(o_r_exc), .o_err(o_err)
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] xs(input logic [63:0] s);
        logic [63:0] a, b;
        a = s ^ (s << 13);
        b = a ^ (a >> 7);
        return b ^ (b << 17);
    endfunction

    // Reference move built straight from the sampling rules; lat counts draws
    task automatic model_move(input logic [63:0] s_in, input int m,
                              output int k, output int l, output int seg, output int lat,
                              output logic [63:0] s_out, output logic [31:0] met,
                              output logic [31:0] exc);
        logic [63:0] s;
        int c, g, t;
        bit done;
        s = s_in; lat = 0; done = 0; k = 0; l = 0; seg = 0;
        while (!done) begin
            do begin
                s = xs(s); lat++; c = int'(s[4:0]);
            end while (!(c >= 1 && c <= ((m == 1) ? CITY_NUM - 1 : CITY_NUM - 2)));
            k = c; seg = 0;
            if (m == 1) begin
                do begin
                    s = xs(s); lat++; g = int'(s[1:0]);
                end while (!(g >= 1 && g <= MAX_SEG && k + g - 1 <= CITY_NUM - 1));
                seg = g;
            end
            s = xs(s); lat++; c = int'(s[4:0]);
            if (m == 1) begin
                if (c < k - 1 || c > k + seg - 1) begin l = c; done = 1; end
            end else if (c - k >= 2 || k - c >= 2) begin
                if (c < k) begin t = k; k = c; l = t; end
                else l = c;
                done = 1;
            end
        end
        s = xs(s); met = s[31:0];
        s = xs(s); exc = s[31:0];
        lat += 2;
        s_out = s;
    endtask

    task automatic load_seed(input logic [63:0] s);
        seed_we = 1'b1; seed_i = s;
        @(posedge clk); #1;
        seed_we = 1'b0;
    endtask

    task automatic do_start(input logic [1:0] m);
        start = 1'b1; mode = m;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_valid(output int lat, output bit to);
        lat = 0;
        while (!out_valid && lat < 300) begin
            @(posedge clk); #1;
            lat++;
        end
        to = !out_valid;
    endtask

    task automatic do_transfer();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (out_valid !== 1'b0 || busy !== 1'b0 || o_com !== 2'd0 || o_err !== 1'b0)
            begin errors++; $display("[TB] FAIL reset_flags: got v=%b b=%b com=%0d err=%b expected 0 0 0 0", out_valid, busy, o_com, o_err); end
        checks++;
        if (seed_o !== 64'h1)
            begin errors++; $display("[TB] FAIL reset_seed: got %h expected %h", seed_o, 64'h1); end
        checks++;
        if (o_k !== '0 || o_l !== '0 || o_seg !== '0 || o_r_met !== '0 || o_r_exc !== '0 || o_base_id !== '0)
            begin errors++; $display("[TB] FAIL reset_data: got k=%0d l=%0d seg=%0d met=%h exc=%h expected zeros", o_k, o_l, o_seg, o_r_met, o_r_exc); end
        reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (seed_o !== 64'h1 || out_valid !== 1'b0)
            begin errors++; $display("[TB] FAIL idle_hold: got seed=%h v=%b expected 1 0", seed_o, out_valid); end
    endtask

    task automatic test_seed_load();
        load_seed(64'hDEAD_BEEF_1234_5678);
        checks++;
        if (seed_o !== 64'hDEAD_BEEF_1234_5678)
            begin errors++; $display("[TB] FAIL seed_load: got %h expected %h", seed_o, 64'hDEAD_BEEF_1234_5678); end
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (seed_o !== 64'hDEAD_BEEF_1234_5678)
            begin errors++; $display("[TB] FAIL seed_idle: got %h expected %h", seed_o, 64'hDEAD_BEEF_1234_5678); end
    endtask

    task automatic test_two();
        int k, l, seg, mlat, lat;
        logic [63:0] ns;
        logic [31:0] met, exc;
        bit to;
        load_seed(64'h1);
        model_move(64'h1, 2, k, l, seg, mlat, ns, met, exc);
        base_id = 5'h15;
        do_start(2'd2);
        base_id = 5'h0A;
        checks++;
        if (busy !== 1'b1 || seed_o !== 64'h1)
            begin errors++; $display("[TB] FAIL two_accept: got busy=%b seed=%h expected 1 %h", busy, seed_o, 64'h1); end
        @(posedge clk); #1;
        checks++;
        if (seed_o !== 64'h40822041)
            begin errors++; $display("[TB] FAIL two_first_draw: got %h expected %h", seed_o, 64'h40822041); end
        wait_valid(lat, to);
        checks++;
        if (to) begin errors++; $display("[TB] FAIL two_timeout: got no out_valid expected out_valid"); return; end
        checks++;
        if (lat + 1 !== mlat)
            begin errors++; $display("[TB] FAIL two_latency: got %0d expected %0d", lat + 1, mlat); end
        checks++;
        if (o_com !== 2'd2 || o_base_id !== 5'h15 || busy !== 1'b0)
            begin errors++; $display("[TB] FAIL two_hdr: got com=%0d base=%h busy=%b expected 2 15 0", o_com, o_base_id, busy); end
        checks++;
        if (int'(o_k) !== k || int'(o_l) !== l || o_seg !== '0 || int'(o_l) - int'(o_k) < 2)
            begin errors++; $display("[TB] FAIL two_idx: got k=%0d l=%0d seg=%0d expected %0d %0d 0", o_k, o_l, o_seg, k, l); end
        checks++;
        if (o_r_met !== met || o_r_exc !== exc || seed_o !== ns)
            begin errors++; $display("[TB] FAIL two_words: got %h %h %h expected %h %h %h", o_r_met, o_r_exc, seed_o, met, exc, ns); end
        do_transfer();
        checks++;
        if (out_valid !== 1'b0)
            begin errors++; $display("[TB] FAIL two_xfer: got v=%b expected 0", out_valid); end
        exp_seed = ns; exp_met = met; exp_exc = exc;
    endtask

    task automatic test_thr();
        int lat;
        bit to;
        logic [1:0] m;
        for (int i = 0; i < 2; i++) begin
            m = (i == 0) ? 2'd0 : 2'd3;
            do_start(m);
            wait_valid(lat, to);
            checks++;
            if (lat !== 1)
                begin errors++; $display("[TB] FAIL thr_latency_m%0d: got %0d expected 1", m, lat); end
            checks++;
            if (o_com !== 2'd0 || o_k !== '0 || o_l !== '0 || o_seg !== '0)
                begin errors++; $display("[TB] FAIL thr_desc_m%0d: got com=%0d k=%0d l=%0d seg=%0d expected zeros", m, o_com, o_k, o_l, o_seg); end
            checks++;
            if (seed_o !== exp_seed || o_r_met !== exp_met || o_r_exc !== exp_exc)
                begin errors++; $display("[TB] FAIL thr_hold_m%0d: got %h %h %h expected %h %h %h", m, seed_o, o_r_met, o_r_exc, exp_seed, exp_met, exp_exc); end
            do_transfer();
        end
    endtask

    task automatic test_or_stress();
        int k, l, seg, mlat, lat, stall;
        logic [63:0] ns;
        logic [31:0] met, exc;
        logic [BASE_W-1:0] b;
        bit to;
        for (int i = 0; i < 1000; i++) begin
            model_move(exp_seed, 1, k, l, seg, mlat, ns, met, exc);
            b = BASE_W'($urandom);
            base_id = b;
            do_start(2'd1);
            base_id = ~b;
            wait_valid(lat, to);
            checks++;
            if (to) begin errors++; $display("[TB] FAIL or_timeout move %0d: got no out_valid expected out_valid", i); return; end
            checks++;
            if (lat !== mlat)
                begin errors++; $display("[TB] FAIL or_latency move %0d: got %0d expected %0d", i, lat, mlat); end
            checks++;
            if (o_com !== 2'd1 || o_base_id !== b)
                begin errors++; $display("[TB] FAIL or_hdr move %0d: got com=%0d base=%h expected 1 %h", i, o_com, o_base_id, b); end
            checks++;
            if (int'(o_k) !== k || int'(o_l) !== l || int'(o_seg) !== seg)
                begin errors++; $display("[TB] FAIL or_idx move %0d: got %0d %0d %0d expected %0d %0d %0d", i, o_k, o_l, o_seg, k, l, seg); end
            checks++;
            if (int'(o_k) < 1 || int'(o_seg) < 1 || int'(o_seg) > MAX_SEG ||
                int'(o_k) + int'(o_seg) - 1 > CITY_NUM - 1 ||
                (int'(o_l) >= int'(o_k) - 1 && int'(o_l) <= int'(o_k) + int'(o_seg) - 1))
                begin errors++; $display("[TB] FAIL or_range move %0d: got k=%0d l=%0d seg=%0d expected legal or-opt", i, o_k, o_l, o_seg); end
            checks++;
            if (o_r_met !== met || o_r_exc !== exc || seed_o !== ns)
                begin errors++; $display("[TB] FAIL or_words move %0d: got %h %h %h expected %h %h %h", i, o_r_met, o_r_exc, seed_o, met, exc, ns); end
            stall = $urandom_range(0, 3);
            for (int j = 0; j < stall; j++) begin
                start = 1'b1; mode = 2'd2;
                @(posedge clk); #1;
                checks++;
                if (out_valid !== 1'b1 || busy !== 1'b0 || int'(o_k) !== k || int'(o_l) !== l ||
                    int'(o_seg) !== seg || o_r_met !== met || o_r_exc !== exc || seed_o !== ns)
                    begin errors++; $display("[TB] FAIL or_stall move %0d: got v=%b k=%0d l=%0d seed=%h expected 1 %0d %0d %h", i, out_valid, o_k, o_l, seed_o, k, l, ns); end
            end
            start = 1'b0;
            do_transfer();
            checks++;
            if (out_valid !== 1'b0 || busy !== 1'b0)
                begin errors++; $display("[TB] FAIL or_xfer move %0d: got v=%b busy=%b expected 0 0", i, out_valid, busy); end
            exp_seed = ns; exp_met = met; exp_exc = exc;
        end
    endtask

    task automatic test_reset_mid_move();
        load_seed(64'h1);
        do_start(2'd2);
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || busy !== 1'b0 || o_com !== 2'd0 || seed_o !== 64'h1)
            begin errors++; $display("[TB] FAIL mid_reset: got v=%b busy=%b com=%0d seed=%h expected 0 0 0 1", out_valid, busy, o_com, seed_o); end
        repeat (10) @(posedge clk);
        #1;
        checks++;
        if (out_valid !== 1'b0 || seed_o !== 64'h1)
            begin errors++; $display("[TB] FAIL mid_reset_quiet: got v=%b seed=%h expected 0 1", out_valid, seed_o); end
        exp_seed = 64'h1; exp_met = '0; exp_exc = '0;
    endtask

`ifdef OPT_RAND_RETRY_LIMIT_EN
    task automatic test_retry_limit();
        logic [63:0] s, a, b;
        int lat;
        bit to, found;
        found = 0; s = '0; a = '0; b = '0;
        for (int i = 0; i < 20000 && !found; i++) begin
            s = {$urandom, $urandom};
            a = xs(s);
            b = xs(a);
            if ((a[4:0] == 5'd0 || a[4:0] == 5'd31) && (b[4:0] == 5'd0 || b[4:0] == 5'd31))
                found = 1;
        end
        if (!found) return;
        load_seed(s);
        do_start(2'd2);
        wait_valid(lat, to);
        checks++;
        if (to || lat !== 2)
            begin errors++; $display("[TB] FAIL retry_latency: got %0d expected 2", lat); end
        checks++;
        if (o_com !== 2'd0 || o_err !== 1'b1 || seed_o !== b)
            begin errors++; $display("[TB] FAIL retry_abort: got com=%0d err=%b seed=%h expected 0 1 %h", o_com, o_err, seed_o, b); end
        do_transfer();
        checks++;
        if (o_err !== 1'b0 || out_valid !== 1'b0)
            begin errors++; $display("[TB] FAIL retry_clear: got err=%b v=%b expected 0 0", o_err, out_valid); end
        exp_seed = b;
    endtask
`endif

    initial begin
        test_reset();
        test_seed_load();
        test_two();
        test_thr();
        test_or_stress();
        test_reset_mid_move();
`ifdef OPT_RAND_RETRY_LIMIT_EN
        test_retry_limit();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
